vga_timing_gen: RTL

Generates VGA raster timing for the pixel-colour stage: hsync, vsync, hpos, vpos and visible, plus line/frame strobes and a frame counter. It is the producing end of the raster interface that the pixel-colour and sprite logic consume, and it sits between the top-level clock/reset and the colour pipeline. The block is one horizontal and one vertical phase FSM, each paired with a position counter, advanced by a pixel clock enable.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// +----------------------------------------------------------------------+
// | vga_timing_pkg : shared VGA timing constants, totals and phase type  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int c_h_display = 640;
  localparam int c_h_front   = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_back    = 48;
  localparam int c_v_display = 480;
  localparam int c_v_front   = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_back    = 33;

  // Position outputs are 10 bits wide, so neither axis may exceed 1024 steps.
  localparam int c_axis_max  = 1024;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic int h_total(input int display, input int front,
                                 input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int v_total(input int display, input int front,
                                 input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +----------------------------------------------------------------------+
// | vga_axis_counter : position counter plus phase FSM for one axis      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = c_h_display,
  parameter int FRONT   = c_h_front,
  parameter int SYNC    = c_h_sync,
  parameter int BACK    = c_h_back
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [9:0] pos,
  output logic [1:0] phase,
  output logic       wrap
);

  localparam int         c_total    = h_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [9:0] c_last     = 10'(c_total - 1);
  localparam logic [9:0] c_front_at = 10'(DISPLAY);
  localparam logic [9:0] c_sync_at  = 10'(DISPLAY + FRONT);
  localparam logic [9:0] c_back_at  = 10'(DISPLAY + FRONT + SYNC);

  if (c_total > c_axis_max) begin : g_total_check
    $error("vga_axis_counter: axis total %0d exceeds %0d", c_total, c_axis_max);
  end

  logic [9:0] pos_q, pos_d;
  phase_e     phase_q, phase_d;

  // Terminal count; the parent gates it with its own advance to cascade axes.
  assign wrap  = (pos_q == c_last);
  assign pos   = pos_q;
  assign phase = phase_q;

  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (advance) begin
      pos_d = wrap ? 10'd0 : pos_q + 10'd1;
      case (phase_q)
        PH_ACTIVE: if (pos_d == c_front_at) phase_d = PH_FRONT;
        PH_FRONT:  if (pos_d == c_sync_at)  phase_d = PH_SYNC;
        PH_SYNC:   if (pos_d == c_back_at)  phase_d = PH_BACK;
        PH_BACK:   if (pos_d == 10'd0)      phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= 10'd0;
      phase_q <= PH_ACTIVE;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen : VGA raster timing (syncs, position, strobes, frames)|
// | Optional macro VGA_TIMING_PIPE_ALIGN_EN delays hsync/vsync/visible.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = c_h_display,
  parameter int H_FRONT         = c_h_front,
  parameter int H_SYNC          = c_h_sync,
  parameter int H_BACK          = c_h_back,
  parameter int V_DISPLAY       = c_v_display,
  parameter int V_FRONT         = c_v_front,
  parameter int V_SYNC          = c_v_sync,
  parameter int V_BACK          = c_v_back,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  localparam logic c_sync_off = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0] h_phase, v_phase;
  logic       h_wrap, v_wrap, v_advance;
  logic       hsync_raw, vsync_raw, visible_raw;
  logic       line_start_q, frame_start_q;
  logic [9:0] frame_count_q;

  assign v_advance = h_wrap & pix_en;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (pix_en),
    .pos     (hpos),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (v_advance),
    .pos     (vpos),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  // Pure decodes of the phase registers, so they change on the same edge as hpos/vpos.
  assign hsync_raw   = (h_phase == PH_SYNC) ? ~c_sync_off : c_sync_off;
  assign vsync_raw   = (v_phase == PH_SYNC) ? ~c_sync_off : c_sync_off;
  assign visible_raw = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 10'd0;
    end else begin
      line_start_q  <= pix_en & h_wrap;
      frame_start_q <= pix_en & h_wrap & v_wrap;
      if (pix_en & h_wrap & v_wrap)
        frame_count_q <= frame_count_q + 10'd1;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  // Matches the one-clock registered sprite ROM read in the colour path.
  logic hsync_q, vsync_q, visible_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q   <= c_sync_off;
      vsync_q   <= c_sync_off;
      visible_q <= 1'b1;
    end else begin
      hsync_q   <= hsync_raw;
      vsync_q   <= vsync_raw;
      visible_q <= visible_raw;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign visible = visible_q;
`else
  assign hsync   = hsync_raw;
  assign vsync   = vsync_raw;
  assign visible = visible_raw;
`endif

endmodule

`default_nettype wire
